// File: rtl/input_vc_buffer.sv
// Router input-port VC buffer: VC_NUM flit FIFOs with per-VC packet FSMs, feeding one
// row of the switch allocator and presenting granted flits to the crossbar a cycle later.
`timescale 1ns/1ps

package noc_params;
  localparam int PORT_NUM  = 5;
  localparam int PORT_SIZE = (PORT_NUM <= 1) ? 1 : $clog2(PORT_NUM);
  typedef logic [PORT_SIZE-1:0] port_t;
endpackage

module ivb_vc
  import noc_params::*;
#(
  parameter int BUF_DEPTH = 4,
  parameter int FLIT_W    = 32,
  localparam int ENT_W    = FLIT_W + PORT_SIZE + 2,
  localparam int PTR_W    = $clog2(BUF_DEPTH),
  localparam int CNT_W    = $clog2(BUF_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [ENT_W-1:0] wr_entry,
  input  logic             pop,
  output logic [ENT_W-1:0] front,
  output logic             full,
  output logic             req,
  output logic             bad_front,
  output port_t            route
);
  typedef enum logic {IDLE, ACTIVE} state_t;
  typedef struct packed {
    logic              head;
    logic              tail;
    port_t             dst;
    logic [FLIT_W-1:0] data;
  } entry_t;

  logic [ENT_W-1:0] mem_q [BUF_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, avail;
  state_t           state_q, state_d;
  port_t            route_q, route_d;
  logic             req_q, req_d;
  entry_t           fr;

  assign fr        = mem_q[rd_ptr_q];
  assign front     = fr;
  assign full      = (cnt_q == CNT_W'(BUF_DEPTH));
  assign req       = req_q;
  assign route     = route_q;
  assign bad_front = (state_q == IDLE) && (cnt_q != '0) && !fr.head;

  always_comb begin
    wr_ptr_d = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    cnt_d    = cnt_q + CNT_W'(wr_en) - CNT_W'(pop);
    avail    = cnt_q - CNT_W'(pop);
    state_d  = state_q;
    route_d  = route_q;
    case (state_q)
      IDLE: if (cnt_q != '0 && fr.head) begin
        state_d = ACTIVE;
        route_d = fr.dst;
      end
      ACTIVE: if (pop && fr.tail) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Request ignores same-cycle writes so a fresh flit waits a full cycle before it can pop.
    req_d = (state_d == ACTIVE) && (avail != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      state_q  <= IDLE;
      route_q  <= '0;
      req_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      route_q  <= route_d;
      req_q    <= req_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_entry;
  end
endmodule

module input_vc_buffer
  import noc_params::*;
#(
  parameter int VC_NUM    = 2,
  parameter int BUF_DEPTH = 4,
  parameter int FLIT_W    = 32,
  localparam int VC_PTR_W = (VC_NUM <= 1) ? 1 : $clog2(VC_NUM),
  localparam int ENT_W    = FLIT_W + PORT_SIZE + 2
) (
  input  logic                     clk,
  input  logic                     RST,
  input  logic                     in_valid,
  input  logic [VC_PTR_W-1:0]      in_vc,
  input  logic                     in_head,
  input  logic                     in_tail,
  input  port_t                    in_dst,
  input  logic [FLIT_W-1:0]        in_data,
  output logic [VC_NUM-1:0]        vc_request,
  output port_t [VC_NUM-1:0]       vc_target_port,
  input  logic [VC_NUM-1:0]        vc_grant,
  output logic                     out_valid,
  output logic [VC_PTR_W-1:0]      out_vc,
  output port_t                    out_port,
  output logic                     out_head,
  output logic                     out_tail,
  output logic [FLIT_W-1:0]        out_data,
  output logic                     credit_valid,
  output logic [VC_PTR_W-1:0]      credit_vc,
  output logic                     err_overflow,
  output logic                     err_proto
);
  typedef struct packed {
    logic              head;
    logic              tail;
    port_t             dst;
    logic [FLIT_W-1:0] data;
  } entry_t;

  logic [VC_NUM-1:0][ENT_W-1:0] front;
  logic [VC_NUM-1:0]            full, bad, wr_en, pop_vec, qual;
  logic [ENT_W-1:0]             wr_ent;
  logic [VC_PTR_W-1:0]          gnt_idx, dsc_idx, pop_idx;
  logic                         gnt_any, gnt_multi, dsc_any, pop_any, in_ok, overflow;
  entry_t                       sel_ent;
  port_t                        sel_route;

  logic                out_valid_q, out_valid_d, out_head_q, out_head_d, out_tail_q, out_tail_d;
  logic [VC_PTR_W-1:0] out_vc_q, out_vc_d, credit_vc_q, credit_vc_d;
  port_t               out_port_q, out_port_d;
  logic [FLIT_W-1:0]   out_data_q, out_data_d;
  logic                credit_valid_q, credit_valid_d;
  logic                err_overflow_q, err_overflow_d, err_proto_q, err_proto_d;

  assign wr_ent = {in_head, in_tail, in_dst, in_data};

  for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
    ivb_vc #(.BUF_DEPTH(BUF_DEPTH), .FLIT_W(FLIT_W)) u_vc (
      .clk       (clk),
      .rst       (RST),
      .wr_en     (wr_en[v]),
      .wr_entry  (wr_ent),
      .pop       (pop_vec[v]),
      .front     (front[v]),
      .full      (full[v]),
      .req       (vc_request[v]),
      .bad_front (bad[v]),
      .route     (vc_target_port[v])
    );
  end

  always_comb begin
    qual      = vc_grant & vc_request;
    gnt_any   = |qual;
    gnt_multi = (qual & (qual - 1'b1)) != '0;
    gnt_idx   = '0;
    dsc_idx   = '0;
    for (int v = VC_NUM - 1; v >= 0; v--) begin
      if (qual[v]) gnt_idx = VC_PTR_W'(v);
      if (bad[v])  dsc_idx = VC_PTR_W'(v);
    end
    // Stray body/tail flits drain only when no granted pop needs the credit port.
    dsc_any = (|bad) && !gnt_any;
    pop_any = gnt_any || dsc_any;
    pop_idx = gnt_any ? gnt_idx : dsc_idx;

    in_ok     = in_valid && (int'(in_vc) < VC_NUM);
    overflow  = 1'b0;
    sel_ent   = '0;
    sel_route = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      pop_vec[v] = pop_any && (pop_idx == VC_PTR_W'(v));
      wr_en[v]   = in_ok && (in_vc == VC_PTR_W'(v)) && (!full[v] || pop_vec[v]);
      if (in_ok && (in_vc == VC_PTR_W'(v)) && full[v] && !pop_vec[v]) overflow = 1'b1;
      if (gnt_idx == VC_PTR_W'(v)) begin
        sel_ent   = front[v];
        sel_route = vc_target_port[v];
      end
    end

    out_valid_d    = gnt_any;
    out_vc_d       = gnt_any ? gnt_idx      : out_vc_q;
    out_port_d     = gnt_any ? sel_route    : out_port_q;
    out_head_d     = gnt_any ? sel_ent.head : out_head_q;
    out_tail_d     = gnt_any ? sel_ent.tail : out_tail_q;
    out_data_d     = gnt_any ? sel_ent.data : out_data_q;
    credit_valid_d = pop_any;
    credit_vc_d    = pop_any ? pop_idx : credit_vc_q;
    err_overflow_d = err_overflow_q || overflow;
    err_proto_d    = err_proto_q || gnt_multi || dsc_any;
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      out_valid_q    <= 1'b0;
      out_vc_q       <= '0;
      out_port_q     <= '0;
      out_head_q     <= 1'b0;
      out_tail_q     <= 1'b0;
      out_data_q     <= '0;
      credit_valid_q <= 1'b0;
      credit_vc_q    <= '0;
      err_overflow_q <= 1'b0;
      err_proto_q    <= 1'b0;
    end else begin
      out_valid_q    <= out_valid_d;
      out_vc_q       <= out_vc_d;
      out_port_q     <= out_port_d;
      out_head_q     <= out_head_d;
      out_tail_q     <= out_tail_d;
      out_data_q     <= out_data_d;
      credit_valid_q <= credit_valid_d;
      credit_vc_q    <= credit_vc_d;
      err_overflow_q <= err_overflow_d;
      err_proto_q    <= err_proto_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_vc       = out_vc_q;
  assign out_port     = out_port_q;
  assign out_head     = out_head_q;
  assign out_tail     = out_tail_q;
  assign out_data     = out_data_q;
  assign credit_valid = credit_valid_q;
  assign credit_vc    = credit_vc_q;
  assign err_overflow = err_overflow_q;
  assign err_proto    = err_proto_q;
endmodule

// File: tb/tb_input_vc_buffer.sv
// Scoreboard bench for input_vc_buffer: expected flits/credits queued at drive time,
// checked as the crossbar side and credit port produce them.
`timescale 1ns/1ps

module tb_input_vc_buffer;
  import noc_params::*;

  localparam int BUF_DEPTH = 4;

  logic        clk = 1'b0;
  logic        RST = 1'b0;
  logic        in_valid = 1'b0;
  logic [0:0]  in_vc = '0;
  logic        in_head = 1'b0, in_tail = 1'b0;
  port_t       in_dst = '0;
  logic [31:0] in_data = '0;
  logic [1:0]  vc_request, vc_grant;
  port_t [1:0] vc_target_port;
  logic        out_valid, out_head, out_tail, credit_valid, err_overflow, err_proto;
  logic [0:0]  out_vc, credit_vc;
  port_t       out_port;
  logic [31:0] out_data;
  logic [1:0]  gnt_mask = '0;

  typedef struct {
    logic        vc;
    port_t       port;
    logic        head;
    logic        tail;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   crd_q[$];
  int   checks = 0, errors = 0;
  int   crd_cnt = 0;
  int   crd_used[2] = '{0, 0};
  int   crd_ret[2]  = '{0, 0};

  always #5 clk = ~clk;

  // The allocator is modelled as granting whatever it is allowed to see.
  assign vc_grant = gnt_mask & vc_request;

  input_vc_buffer #(.VC_NUM(2), .BUF_DEPTH(BUF_DEPTH), .FLIT_W(32)) dut (
    .clk(clk), .RST(RST), .in_valid(in_valid), .in_vc(in_vc), .in_head(in_head),
    .in_tail(in_tail), .in_dst(in_dst), .in_data(in_data), .vc_request(vc_request),
    .vc_target_port(vc_target_port), .vc_grant(vc_grant), .out_valid(out_valid),
    .out_vc(out_vc), .out_port(out_port), .out_head(out_head), .out_tail(out_tail),
    .out_data(out_data), .credit_valid(credit_valid), .credit_vc(credit_vc),
    .err_overflow(err_overflow), .err_proto(err_proto)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!RST) begin
      if (out_valid) begin
        if (exp_q.size() == 0) chk("unexpected_out", 1, 0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("out_data", out_data, e.data);
          chk("out_vc", out_vc, e.vc);
          chk("out_port", out_port, e.port);
          chk("out_head_tail", {out_head, out_tail}, {e.head, e.tail});
        end
      end
      if (credit_valid) begin
        crd_cnt++;
        crd_ret[credit_vc]++;
        if (crd_q.size() == 0) chk("unexpected_credit", 1, 0);
        else chk("credit_vc", credit_vc, crd_q.pop_front());
      end
    end
  end

  // kind: 0 = flit expected lost, 1 = delivered + credit, 2 = discarded + credit
  task automatic put(input int vc, input bit h, input bit t, input int dst,
                     input logic [31:0] d, input int kind, input bit fc);
    int n = 0;
    if (fc) begin
      while (crd_used[vc] - crd_ret[vc] >= BUF_DEPTH && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (n >= 200) chk("fc_wait_timeout", 1, 0);
      crd_used[vc]++;
    end
    in_vc    = 1'(vc);
    in_head  = h;
    in_tail  = t;
    in_dst   = port_t'(dst);
    in_data  = d;
    in_valid = 1'b1;
    if (kind == 1) exp_q.push_back('{1'(vc), port_t'(dst), h, t, d});
    if (kind != 0) crd_q.push_back(vc);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain(input int max);
    int n = 0;
    while ((exp_q.size() != 0 || crd_q.size() != 0) && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("drain_flits_left", exp_q.size(), 0);
    chk("drain_credits_left", crd_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_req(input logic [1:0] bits, input int max);
    int n = 0;
    while ((vc_request & bits) != bits && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("wait_request", vc_request & bits, bits);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    repeat (2) @(negedge clk);
    exp_q.delete();
    crd_q.delete();
    RST = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int c0;
    #1 RST = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_flags", {out_valid, credit_valid, err_overflow, err_proto, out_head, out_tail}, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_tgt_port", vc_target_port, 0);
    RST = 1'b0;
    @(negedge clk);
    chk("reset_request", vc_request, 0);

    // 3-flit packet on VC0 toward port 2
    gnt_mask = 2'b11;
    c0 = crd_cnt;
    put(0, 1, 0, 2, 32'hA000_0001, 1, 0);
    put(0, 0, 0, 2, 32'hA000_0002, 1, 0);
    put(0, 0, 1, 2, 32'hA000_0003, 1, 0);
    drain(50);
    chk("pkt3_credits", crd_cnt - c0, 3);
    chk("pkt3_vc0_idle_req", vc_request[0], 0);

    // Overflow on VC1, then a write into a full VC alongside a pop
    gnt_mask = 2'b00;
    put(1, 1, 0, 3, 32'hB000_0001, 1, 0);
    put(1, 0, 0, 3, 32'hB000_0002, 1, 0);
    put(1, 0, 0, 3, 32'hB000_0003, 1, 0);
    put(1, 0, 0, 3, 32'hB000_0004, 1, 0);
    chk("ovf_before", err_overflow, 0);
    put(1, 0, 0, 3, 32'hDEAD_DEAD, 0, 0);
    chk("ovf_set", err_overflow, 1);
    wait_req(2'b10, 20);
    gnt_mask = 2'b10;
    put(1, 0, 1, 3, 32'hB000_0005, 1, 0);
    gnt_mask = 2'b11;
    drain(50);

    // Simultaneous requests with a multi-hot grant
    gnt_mask = 2'b00;
    put(0, 1, 1, 1, 32'hC000_0000, 1, 0);
    put(1, 1, 1, 3, 32'hC000_0001, 1, 0);
    wait_req(2'b11, 20);
    chk("tgt_port_pair", vc_target_port, {port_t'(3), port_t'(1)});
    chk("proto_before_multi", err_proto, 0);
    gnt_mask = 2'b11;
    @(negedge clk);
    chk("proto_multi_grant", err_proto, 1);
    drain(50);

    do_reset();
    chk("reset_clears_proto", err_proto, 0);

    // Stray body flit into an IDLE VC
    put(0, 0, 0, 0, 32'hBAD0_0000, 2, 0);
    for (int i = 0; i < 4; i++) begin
      chk("body_idle_no_req", vc_request[0], 0);
      @(negedge clk);
    end
    chk("body_idle_proto", err_proto, 1);
    drain(20);

    // Stream single-flit packets through VC0 under credit flow control
    crd_used = '{0, 0};
    crd_ret  = '{0, 0};
    gnt_mask = 2'b11;
    c0 = crd_cnt;
    for (int i = 0; i < 3 * BUF_DEPTH; i++)
      put(0, 1, 1, i % 5, 32'h6000_0000 + i, 1, 1);
    drain(300);
    chk("wrap_credits", crd_cnt - c0, 3 * BUF_DEPTH);

    // Asynchronous reset in the middle of a packet
    gnt_mask = 2'b00;
    put(1, 1, 0, 3, 32'h1111_1111, 0, 0);
    repeat (3) @(negedge clk);
    chk("pre_rst_tgt", vc_target_port[1], 3);
    #2 RST = 1'b1;
    #1;
    chk("async_rst_flags", {out_valid, credit_valid, err_overflow, err_proto, out_head, out_tail}, 0);
    chk("async_rst_data", out_data, 0);
    chk("async_rst_tgt", vc_target_port, 0);
    chk("async_rst_req", vc_request, 0);
    exp_q.delete();
    crd_q.delete();
    @(negedge clk);
    RST = 1'b0;
    @(negedge clk);
    chk("post_rst_req", vc_request, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got 1 exp 0");
    $fatal(1, "timeout");
  end
endmodule
